// File: rtl/fetch_sequencer_pkg.sv
// Shared types and opcode constants for the fetch sequencer.
// Used by fetch_sequencer and fetch_fifo.
package fetch_sequencer_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [5:0]  OPC_HLT  = 6'h3F;
    localparam logic [5:0]  OPC_J    = 6'h02;
    localparam logic [5:0]  OPC_JAL  = 6'h03;
    localparam logic [31:0] HLT_WORD = {OPC_HLT, 26'd0};

    function automatic logic [5:0] opcode(input logic [31:0] inst);
        return inst[31:26];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH x {pc, inst}, wrap-around pointers plus occupancy count.
// Flush empties the buffer and overrides push/pop in the same cycle.
module fetch_fifo
    import fetch_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    // Head is forced to zero when empty so outputs are clean out of reset.
    assign rdata = empty ? 64'd0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (!push && pop)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC, RUN/HALT FSM, fetch buffer, redirect.
// Optional FETCH_JUMP_PREDECODE_EN follows j/jal targets at fetch time.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        halted
);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] seq_pc;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic        is_hlt;
    logic [63:0] head;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata ({pc, imem_rdata}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign imem_addr = pc;
    assign out_valid = !empty;
    assign out_pc    = head[63:32];
    assign out_inst  = head[31:0];
    assign pop       = out_valid && out_ready && !redirect_valid;
    assign is_hlt    = (imem_rdata == HLT_WORD);

`ifdef FETCH_JUMP_PREDECODE_EN
    always_comb begin
        seq_pc = pc + 32'd1;
        if (opcode(imem_rdata) == OPC_J || opcode(imem_rdata) == OPC_JAL)
            seq_pc = {pc[31:26], imem_rdata[25:0]};
    end
`else
    assign seq_pc = pc + 32'd1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Redirect wins over everything, including leaving HALT.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        if (redirect_valid) begin
            state_nxt = RUN;
            pc_nxt    = redirect_pc;
        end else if (push) begin
            if (is_hlt)
                state_nxt = HALT;
            else
                pc_nxt = seq_pc;
        end
    end

    always_comb begin
        halted = (state == HALT);
        push   = (state == RUN) && (!full || pop) && !redirect_valid;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, fetch buffer entries (power of 2, >=2).
REQ-002 Parameter RESET_PC, default 32'd0, word index fetched first after reset.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 imem_addr  output  32  word index presented to instruction memory (equals current PC).
REQ-006 imem_rdata  input  32  instruction word at imem_addr, combinational read, same cycle.
REQ-007 redirect_valid  input  1  branch/jump resolution, flush and restart request.
REQ-008 redirect_pc  input  32  word index to restart at when redirect_valid=1.
REQ-009 out_valid  output  1  head instruction available to decode/dispatch.
REQ-010 out_ready  input  1  consumer accepts head when out_valid=1.
REQ-011 out_inst  output  32  head instruction word.
REQ-012 out_pc  output  32  word index of out_inst.
REQ-013 halted  output  1  high while in HALT state.

Function
REQ-014 PC SHALL be a word index; sequential next PC = PC+1, modulo 2^32 (32'hFFFFFFFF wraps to 0).
REQ-015 State machine SHALL have states RUN and HALT; reset enters RUN.
REQ-016 In RUN, when buffer not full or a pop occurs the same cycle, {PC, imem_rdata} SHALL be pushed at the clock edge and PC advanced.
REQ-017 In RUN with buffer full and no pop, PC and buffer SHALL hold (no fetch, no loss).
REQ-018 A pop SHALL occur when out_valid && out_ready; out_valid = buffer not empty; out_inst/out_pc SHALL be combinational from buffer head.
REQ-019 Fetch-to-out_valid latency SHALL be 1 cycle (instruction fetched at edge N is visible after edge N).
REQ-020 Pushed word 32'hFC000000 (opcode 6'h3F, hlt) SHALL be buffered normally, PC SHALL NOT advance, state SHALL go to HALT.
REQ-021 In HALT no push SHALL occur; buffered instructions SHALL still drain via handshake.
REQ-022 redirect_valid SHALL take priority over push and pop: buffer emptied, PC <= redirect_pc, state <= RUN (also from HALT), no push that cycle; a pop handshaking that cycle is discarded.
REQ-023 After redirect, first instruction from redirect_pc SHALL fetch on the next edge.
REQ-024 halted SHALL be 1 exactly when state is HALT.

Reset
REQ-025 On rst: PC=RESET_PC, buffer empty, state RUN, out_valid=0, out_inst=0, out_pc=0, halted=0, regardless of clk.
REQ-026 Reset asserted mid-operation (including HALT or full buffer) SHALL discard all buffered instructions.
REQ-027 First fetch SHALL occur on the first rising clk edge after rst deasserts.

Configuration
REQ-028 Macro FETCH_JUMP_PREDECODE_EN: when defined, a pushed word with opcode 6'h02 (j) SHALL set next PC = {PC[31:26], inst[25:0]} instead of PC+1 (jal 6'h03 likewise); the j/jal itself is still buffered.
REQ-029 Without FETCH_JUMP_PREDECODE_EN, j/jal SHALL be treated as ordinary instructions (PC+1); redirect is the only PC override.

Structure
REQ-030 Shared package SHALL hold: state enum (RUN, HALT), OPC_HLT=6'h3F, OPC_J=6'h02, OPC_JAL=6'h03, HLT_WORD=32'hFC000000.
REQ-031 Buffer SHALL be sub-module fetch_fifo (DEPTH entries x 64 bits {pc,inst}, push/pop/flush, full/empty, wrap-around pointers with occupancy counter).

Verification
REQ-032 Memory: 0:2001007B,1:00211020,2:2042007B,3:20030000,4:206303E7,5:FC000000; out_ready=1 -> out_pc 0..5 in order, one per cycle, halted=1 after word 5 pushed, imem_addr stays 5.
REQ-033 Same program, out_ready=0 for 10 cycles -> exactly 4 entries (pc 0..3), imem_addr=4 held; release -> pc 0..5 delivered with no gaps or duplicates.
REQ-034 Redirect to 32'd2 at cycle when out_pc=1 handshakes -> pc 1 discarded, next out_pc sequence 2,3,4,5.
REQ-035 While halted with buffer empty, redirect_pc=0 -> halted=0 next cycle, out_pc 0 valid one cycle later.
REQ-036 RESET_PC=32'hFFFFFFFF, nops everywhere -> out_pc FFFFFFFF then 00000000.
REQ-037 With FETCH_JUMP_PREDECODE_EN, word at 1 = 32'h08000004 (j 4) -> out_pc sequence 0,1,4,5; without macro -> 0,1,2,3,4,5.
